// File: rtl/encoder_42_seq_if.sv
// Index handshake between encoder_42_seq and a single-index consumer.
// The encoder is the master: it offers y with out_valid; the consumer
// answers with out_ready. A transfer happens on any rising edge where
// both are high.
interface encoder_42_seq_if;
  logic [1:0] y;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output y,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  y,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/encoder_42_seq.sv
// encoder_42_seq: sequential 4-to-2 encoder.
// Request pulses on i[3:0] are captured into a sticky pending set. Each
// pending line is then offered, one at a time, as a 2-bit index on a
// valid/ready handshake, and its pending bit is cleared when accepted.
//
// Optional build macro:
//   ENC_ROUND_ROBIN_EN - rotating priority. The search starts just above
//                        the last accepted index. Without it, the lowest
//                        pending index always wins.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing offered; waits for any pending bit
// OFFER | y/out_valid held stable until accepted; after an acceptance,
//       | moves straight to the next remaining line with no gap
module encoder_42_seq (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enb,
  input  logic [3:0]              i,
  encoder_42_seq_if.master        out_if,
  output logic [3:0]              pending,
  output logic                    ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] y_q, y_d;
  logic       out_valid_q, out_valid_d;
  logic       ovf_q, ovf_d;

  logic       hs;
  logic [3:0] clr;
  logic [3:0] req;
  logic [3:0] rem;
  logic [1:0] sel_pend;
  logic [1:0] sel_rem;

  // Lowest set index of m. Only meaningful when m is non-zero.
  function automatic logic [1:0] sel_low(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[3]) idx = 2'd3;
    if (m[2]) idx = 2'd2;
    if (m[1]) idx = 2'd1;
    if (m[0]) idx = 2'd0;
    return idx;
  endfunction

  // Handshake, the one-hot clear for the accepted line, and new requests.
  always_comb begin
    hs  = out_valid_q & out_if.out_ready;
    clr = hs ? (4'b0001 << y_q) : 4'b0000;
    req = enb ? i : 4'b0000;
    rem = pending_q & ~clr;
  end

`ifdef ENC_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;

  // Rotate m so that index 'start' sits at bit 0, pick the lowest set bit,
  // then rotate the result back. The 2-bit add wraps mod 4.
  function automatic logic [1:0] sel_rr(input logic [3:0] m,
                                        input logic [1:0] start);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {m, m};
    rot = dbl[start +: 4];
    return sel_low(rot) + start;
  endfunction

  // Pointer follows the accepted index; searches start one above it.
  always_comb begin
    last_d   = hs ? y_q : last_q;
    sel_pend = sel_rr(pending_q, last_q + 2'd1);
    sel_rem  = sel_rr(rem, y_q + 2'd1);
  end

  // Last-accepted pointer; resets to 3 so the first search begins at line 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 2'd3;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    sel_pend = sel_low(pending_q);
    sel_rem  = sel_low(rem);
  end
`endif

  // Pending set and sticky overflow. A new request on the line being
  // cleared in the same cycle re-pends it and is not an overflow.
  always_comb begin
    pending_d = rem | req;
    ovf_d     = ovf_q | (|(req & rem));
  end

  // Offer FSM: next state, offered index and valid.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (pending_q != 4'b0000) begin
          y_d         = sel_pend;
          out_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          if (rem != 4'b0000) begin
            y_d = sel_rem;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, offer and status registers; reset drops everything at once,
  // including an index that was on offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 4'b0000;
      y_q         <= 2'd0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Registered outputs.
  always_comb begin
    out_if.y         = y_q;
    out_if.out_valid = out_valid_q;
    pending          = pending_q;
    ovf              = ovf_q;
  end

endmodule

// File: tb/tb_encoder_42_seq.sv
// Directed bench for encoder_42_seq (default fixed-priority build).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_encoder_42_seq;

  logic       clk;
  logic       rst_n;
  logic       enb;
  logic [3:0] i;
  logic [3:0] pending;
  logic       ovf;

  int total;
  int bad;

  encoder_42_seq_if bus ();

  encoder_42_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enb     (enb),
    .i       (i),
    .out_if  (bus.master),
    .pending (pending),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_pend,
                         input logic e_valid, input logic [1:0] e_y, input logic e_ovf);
    chk({tag, ".pending"}, {4'h0, pending}, {4'h0, e_pend});
    chk({tag, ".valid"}, {7'h0, bus.out_valid}, {7'h0, e_valid});
    chk({tag, ".y"}, {6'h0, bus.y}, {6'h0, e_y});
    chk({tag, ".ovf"}, {7'h0, ovf}, {7'h0, e_ovf});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    enb   = 1'b0;
    i     = 4'h0;
    bus.out_ready = 1'b0;

    // 1: reset values, then async reset from a busy state
    tick();
    tick();
    chk_all("rst_init", 4'h0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    enb   = 1'b1;
    i     = 4'hF;
    tick();
    chk_all("fill1", 4'hF, 1'b0, 2'd0, 1'b0);
    tick();
    chk_all("fill2", 4'hF, 1'b1, 2'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 4'h0, 1'b0, 2'd0, 1'b0);
    tick();
    chk_all("rst_hold_iF", 4'h0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    i     = 4'h0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk_all("idle", 4'h0, 1'b0, 2'd0, 1'b0);

    // 2: single request on line 2, two-cycle latency, one-cycle offer
    i = 4'b0100;
    tick();
    i = 4'h0;
    chk_all("single_pend", 4'b0100, 1'b0, 2'd0, 1'b0);
    tick();
    chk_all("single_offer", 4'b0100, 1'b1, 2'd2, 1'b0);
    tick();
    chk("single_done.valid", {7'h0, bus.out_valid}, 8'h0);
    chk("single_done.pending", {4'h0, pending}, 8'h0);

    // 3: drain 1011 back-to-back: 0,1,3
    i = 4'b1011;
    tick();
    i = 4'h0;
    tick();
    chk_all("drain_y0", 4'b1011, 1'b1, 2'd0, 1'b0);
    tick();
    chk_all("drain_y1", 4'b1010, 1'b1, 2'd1, 1'b0);
    tick();
    chk_all("drain_y3", 4'b1000, 1'b1, 2'd3, 1'b0);
    tick();
    chk_all("drain_end", 4'b0000, 1'b0, 2'd3, 1'b0);

    // 4: stall with line 1 offered; higher-priority arrival must not change y
    bus.out_ready = 1'b0;
    i = 4'b0010;
    tick();
    i = 4'h0;
    tick();
    chk_all("stall_start", 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall.y", {6'h0, bus.y}, 8'd1);
      chk("stall.valid", {7'h0, bus.out_valid}, 8'd1);
    end
    i = 4'b0001;
    tick();
    i = 4'h0;
    chk_all("stall_hipri", 4'b0011, 1'b1, 2'd1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk_all("stall_next", 4'b0001, 1'b1, 2'd0, 1'b0);
    tick();
    chk_all("stall_end", 4'b0000, 1'b0, 2'd0, 1'b0);

    // 5: overflow on re-pulse while offered, set-wins in the hs cycle
    bus.out_ready = 1'b0;
    i = 4'b0010;
    tick();
    i = 4'h0;
    tick();
    chk_all("ovf_offer", 4'b0010, 1'b1, 2'd1, 1'b0);
    i = 4'b0010;
    tick();
    i = 4'h0;
    chk_all("ovf_set", 4'b0010, 1'b1, 2'd1, 1'b1);
    i = 4'b0010;
    bus.out_ready = 1'b1;
    tick();
    i = 4'h0;
    chk_all("setwins_hs", 4'b0010, 1'b0, 2'd1, 1'b1);
    tick();
    chk_all("setwins_reoffer", 4'b0010, 1'b1, 2'd1, 1'b1);
    tick();
    chk_all("setwins_end", 4'b0000, 1'b0, 2'd1, 1'b1);

    // 6: enb=0 ignores requests
    bus.out_ready = 1'b0;
    enb = 1'b0;
    i   = 4'hF;
    tick();
    tick();
    chk_all("enb0_ignore", 4'b0000, 1'b0, 2'd1, 1'b1);

    //    enb=0 still drains; reset mid-drain clears at once
    enb = 1'b1;
    i   = 4'b0101;
    tick();
    i = 4'h0;
    bus.out_ready = 1'b1;
    tick();
    chk_all("enb0_first", 4'b0101, 1'b1, 2'd0, 1'b1);
    enb = 1'b0;
    i   = 4'hF;
    tick();
    chk_all("enb0_drain", 4'b0100, 1'b1, 2'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_middrain", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    chk_all("rst_middrain_hold", 4'b0000, 1'b0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
